// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/DMA memory arbiter.
// State encoding, address map and device strobe bundle.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU,
        ST_DMA_ADDR,
        ST_DMA_DATA,
        ST_DMA_ACK
    } arb_state_t;

    localparam logic [15:0] SRAM_BASE = 16'h0000;
    localparam logic [15:0] SRAM_TOP  = 16'h1FFF;
    localparam logic [15:0] IO_TOP    = 16'h7FFF;
    localparam logic [15:0] ROM_BASE  = 16'h8000;

    typedef struct packed {
        logic sram_en;
        logic sram_we;
        logic rom_oe;
        logic io_sel;
    } strobe_t;

    localparam strobe_t STB_NONE = '0;

endpackage

// File: rtl/addr_decode.sv
// Combinational CPU address decode into device strobes.
// Shared with board-level logic that needs the same map.
module addr_decode
    import mem_arbiter_pkg::*;
(
    input  logic [15:0] addr,
    input  logic        rw,
    output strobe_t     stb
);

    logic in_sram;
    logic in_io;
    logic in_rom;

    // Region select from the map, then qualify by direction.
    always_comb begin
        in_sram     = (addr & ~SRAM_TOP) == SRAM_BASE;
        in_rom      = addr >= ROM_BASE;
        in_io       = !in_sram && (addr <= IO_TOP);
        stb.sram_en = in_sram;
        stb.sram_we = in_sram & ~rw;
        stb.rom_oe  = in_rom & rw;
        stb.io_sel  = in_io;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory bus between the CPU (phi_0 high)
// and one FDC DMA transfer per phi_0-low phase.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LOW_MIN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phi_0,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_wdata,
    input  logic        dma_req,
    input  logic [12:0] dma_addr,
    input  logic        dma_rw,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        sram_en,
    output logic        sram_we,
    output logic        rom_oe,
    output logic        io_sel
);

    // LOW_MIN only bounds the bus timing; no logic depends on it.
    if (LOW_MIN > 0) begin : g_low_min
    end

    arb_state_t state;
    arb_state_t nxt;
    logic       phi_q;
    logic       rise;
    logic       fall;
    strobe_t    cpu_stb;
    strobe_t    stb_q;

    assign rise = phi_0 & ~phi_q;
    assign fall = ~phi_0 & phi_q;

    addr_decode u_dec (
        .addr (cpu_addr),
        .rw   (cpu_rw),
        .stb  (cpu_stb)
    );

    // Phase edge history for rise/fall detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) phi_q <= 1'b0;
        else      phi_q <= phi_0;
    end

    // Next state: a CPU phase start pre-empts everything.
    always_comb begin
        nxt = state;
        if (rise) begin
            nxt = ST_CPU;
        end else begin
            unique case (state)
                ST_CPU:      if (fall) nxt = dma_req ? ST_DMA_ADDR : ST_IDLE;
                ST_DMA_ADDR: nxt = ST_DMA_DATA;
                ST_DMA_DATA: nxt = ST_DMA_ACK;
                ST_DMA_ACK:  nxt = ST_IDLE;
                default:     nxt = ST_IDLE;
            endcase
        end
    end

    // State and registered bus outputs for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            stb_q     <= STB_NONE;
            dma_ack   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            dma_rdata <= '0;
        end else begin
            state   <= nxt;
            dma_ack <= (nxt == ST_DMA_ACK);
            if (state == ST_DMA_DATA && dma_rw) dma_rdata <= mem_rdata;
            unique case (nxt)
                ST_CPU: begin
                    mem_addr  <= cpu_addr;
                    mem_wdata <= cpu_wdata;
                    stb_q     <= cpu_stb;
                end
                ST_DMA_ADDR, ST_DMA_DATA: begin
                    mem_addr      <= {3'b000, dma_addr};
                    mem_wdata     <= dma_wdata;
                    stb_q         <= STB_NONE;
                    stb_q.sram_en <= 1'b1;
                    stb_q.sram_we <= ~dma_rw;
                end
                default: stb_q <= STB_NONE;
            endcase
        end
    end

    assign sram_en = stb_q.sram_en;
    assign sram_we = stb_q.sram_we;
    assign rom_oe  = stb_q.rom_oe;
    assign io_sel  = stb_q.io_sel;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a synchronous
// SRAM/ROM model behind the shared bus.
module tb_mem_arbiter;

    localparam int HI_LEN = 4;

    logic        clk;
    logic        rst;
    logic        phi_0;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_wdata;
    logic        dma_req;
    logic [12:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  dma_wdata;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        sram_en;
    logic        sram_we;
    logic        rom_oe;
    logic        io_sel;

    typedef struct packed {
        logic       rd;
        logic [7:0] data;
    } dma_exp_t;

    dma_exp_t   dma_q[$];
    logic [7:0] cpu_q[$];
    logic [7:0] ref_mem [logic [15:0]];
    logic [7:0] sram [0:8191];
    dma_exp_t   e;

    int vectors     = 0;
    int miscompares = 0;
    int ack_cnt     = 0;
    int acks0;

    mem_arbiter #(.LOW_MIN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .phi_0     (phi_0),
        .cpu_addr  (cpu_addr),
        .cpu_rw    (cpu_rw),
        .cpu_wdata (cpu_wdata),
        .dma_req   (dma_req),
        .dma_addr  (dma_addr),
        .dma_rw    (dma_rw),
        .dma_wdata (dma_wdata),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .rom_oe    (rom_oe),
        .io_sel    (io_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Memory behind the bus: data one clk after address/enable.
    always @(posedge clk) begin
        if (sram_en && sram_we) sram[mem_addr[12:0]] <= mem_wdata;
        mem_rdata <= rom_oe ? rom_byte(mem_addr) : sram[mem_addr[12:0]];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_stb(input logic [15:0] a,
                                           input logic rw);
        logic sr, ro, io;
        sr = a < 16'h2000;
        ro = a >= 16'h8000;
        io = !sr && !ro;
        return {sr, sr & ~rw, ro & rw, io};
    endfunction

    // Ack monitor: pops the DMA scoreboard on each ack.
    always @(negedge clk) begin
        if (rst && dma_ack) begin
            ack_cnt++;
            if (dma_q.size() == 0) begin
                check("ack_unexp", dma_ack, 0);
            end else begin
                e = dma_q.pop_front();
                if (e.rd) check("dma_rdata", dma_rdata, e.data);
            end
        end
    end

    task automatic dma_start(input logic [12:0] a, input logic rw,
                             input logic [7:0] wd);
        dma_exp_t x;
        dma_addr  = a;
        dma_rw    = rw;
        dma_wdata = wd;
        dma_req   = 1'b1;
        x.rd      = rw;
        x.data    = rw ? ref_mem[{3'b000, a}] : 8'h00;
        if (!rw) ref_mem[{3'b000, a}] = wd;
        dma_q.push_back(x);
    endtask

    task automatic high_phase(input logic [15:0] a, input logic rw,
                              input logic [7:0] wd);
        bit has_data;
        cpu_addr  = a;
        cpu_rw    = rw;
        cpu_wdata = wd;
        phi_0     = 1'b1;
        has_data  = 1'b0;
        if (rw && a < 16'h2000) begin
            cpu_q.push_back(ref_mem[a]);
            has_data = 1'b1;
        end else if (rw && a >= 16'h8000) begin
            cpu_q.push_back(rom_byte(a));
            has_data = 1'b1;
        end
        if (!rw && a < 16'h2000) ref_mem[a] = wd;
        for (int i = 1; i <= HI_LEN; i++) begin
            @(negedge clk);
            check("cpu_stb", {sram_en, sram_we, rom_oe, io_sel},
                  exp_stb(a, rw));
            check("cpu_addr", mem_addr, a);
            if (i == 1) check("hi_ack", dma_ack, 0);
            if (i == 1 && !rw) check("cpu_wdata", mem_wdata, wd);
            if (i == HI_LEN && has_data)
                check("cpu_rdata", mem_rdata, cpu_q.pop_front());
        end
    endtask

    task automatic low_phase(input int n);
        bit xfer;
        int ack_at;
        xfer   = dma_req;
        ack_at = 0;
        phi_0  = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (dma_ack) begin
                ack_at  = i;
                dma_req = 1'b0;
            end
            if (xfer && i <= 2) begin
                check("dma_stb", {sram_en, sram_we, rom_oe, io_sel},
                      {1'b1, ~dma_rw, 2'b00});
                check("dma_addr", mem_addr, {3'b000, dma_addr});
                if (!dma_rw) check("dma_wdata", mem_wdata, dma_wdata);
            end else begin
                check("low_stb", {sram_en, sram_we, rom_oe, io_sel}, 0);
                if (!xfer) check("idle_addr", mem_addr, cpu_addr);
            end
        end
        check("ack_at", ack_at, (xfer && n >= 4) ? 3 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        phi_0     = 1'b0;
        cpu_addr  = '0;
        cpu_rw    = 1'b1;
        cpu_wdata = '0;
        dma_req   = 1'b0;
        dma_addr  = '0;
        dma_rw    = 1'b1;
        dma_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_stb", {sram_en, sram_we, rom_oe, io_sel}, 0);
        check("rst_ack", dma_ack, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", dma_rdata, 0);
        rst = 1'b1;

        // ROM read, SRAM write/read, IO, write to ROM space.
        high_phase(16'h8000, 1'b1, 8'h00);
        low_phase(4);
        high_phase(16'h0000, 1'b0, 8'hAA);
        low_phase(4);
        high_phase(16'h0000, 1'b1, 8'h00);
        low_phase(4);
        high_phase(16'h4000, 1'b1, 8'h00);
        low_phase(4);
        high_phase(16'h9000, 1'b0, 8'h12);
        low_phase(4);

        // DMA write to top of SRAM, then CPU readback.
        dma_start(13'h1FFF, 1'b0, 8'h55);
        high_phase(16'h8001, 1'b1, 8'h00);
        low_phase(4);
        high_phase(16'h1FFF, 1'b1, 8'h00);
        low_phase(4);

        // DMA read of the CPU-written byte.
        dma_start(13'h0000, 1'b1, 8'h00);
        high_phase(16'h8002, 1'b1, 8'h00);
        low_phase(4);
        high_phase(16'h2000, 1'b1, 8'h00);
        check("rdata_hold", dma_rdata, 8'hAA);
        low_phase(4);

        // Short low phase aborts; the retry completes.
        dma_start(13'h0100, 1'b0, 8'h33);
        high_phase(16'h8003, 1'b1, 8'h00);
        low_phase(2);
        high_phase(16'h8004, 1'b1, 8'h00);
        low_phase(4);
        high_phase(16'h0100, 1'b1, 8'h00);
        low_phase(4);

        // Reset landing in DMA_DATA of a read.
        dma_start(13'h0200, 1'b1, 8'h00);
        high_phase(16'h8005, 1'b1, 8'h00);
        phi_0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_en", sram_en, 1);
        acks0 = ack_cnt;
        rst = 1'b0;
        #1;
        check("mid_rst_stb", {sram_en, sram_we, rom_oe, io_sel}, 0);
        check("mid_rst_ack", dma_ack, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_rdata", dma_rdata, 0);
        dma_req = 1'b0;
        dma_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        high_phase(16'h1FFF, 1'b1, 8'h00);
        low_phase(4);
        check("no_ack_after_rst", ack_cnt, acks0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LOW_MIN, default 4, minimum phi_0-low length in clk cycles; the integrator guarantees it, and the block does not check it.
REQ-002 clk  input  1  system clock; single clock domain.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 phi_0  input  1  CPU bus phase from clock_gen, synchronous to clk; high = CPU phase.
REQ-005 cpu_addr  input  16  CPU address.
REQ-006 cpu_rw  input  1  1 = read, 0 = write.
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 dma_req  input  1  FDC DMA request; held high until dma_ack.
REQ-009 dma_addr  input  13  SRAM word address, $0000-$1FFF.
REQ-010 dma_rw  input  1  1 = read, 0 = write.
REQ-011 dma_wdata  input  8  DMA write data.
REQ-012 dma_ack  output  1  one-cycle completion pulse.
REQ-013 dma_rdata  output  8  DMA read data; valid when dma_ack = 1, held until the next DMA read.
REQ-014 mem_addr  output  16  shared bus address.
REQ-015 mem_wdata  output  8  shared bus write data.
REQ-016 mem_rdata  input  8  SRAM/ROM read data, valid one clk after the address and enable are presented.
REQ-017 sram_en, sram_we, rom_oe, io_sel  output  1 each  active-high device strobes.

Function
REQ-018 phi_0 is registered into phi_q each clk.
- rise = phi_0 & ~phi_q
- fall = ~phi_0 & phi_q
REQ-019 FSM states: IDLE, CPU, DMA_ADDR, DMA_DATA, DMA_ACK.
REQ-020 Transitions:
- any state -> CPU on rise
- CPU -> DMA_ADDR on fall with dma_req = 1
- CPU -> IDLE on fall with dma_req = 0
- DMA_ADDR -> DMA_DATA -> DMA_ACK -> IDLE, one clk each
REQ-021 A DMA transfer is granted at most once per phi_0-low phase; a request raised while in IDLE waits for the next fall.
REQ-022 All outputs are registered and reflect the state entered on the same edge.
REQ-023 CPU state drives mem_addr = cpu_addr and mem_wdata = cpu_wdata, with these strobes:
- sram_en = (cpu_addr[15:13] == 0)
- sram_we = sram_en & ~cpu_rw
- rom_oe = cpu_addr[15] & cpu_rw
- io_sel = (cpu_addr[15:13] != 0) & ~cpu_addr[15]
REQ-024 A CPU write to ROM space asserts no strobe.
REQ-025 DMA_ADDR and DMA_DATA drive mem_addr = {3'b000, dma_addr} and mem_wdata = dma_wdata, with sram_en = 1 and sram_we = ~dma_rw; rom_oe and io_sel are 0.
REQ-026 In DMA_DATA with dma_rw = 1, dma_rdata captures mem_rdata.
REQ-027 DMA_ACK drives dma_ack = 1 and all strobes 0.
REQ-028 IDLE drives all strobes 0 and holds mem_addr.
REQ-029 A rise during DMA_ADDR or DMA_DATA aborts the transfer:
- the FSM goes to CPU
- no dma_ack is issued
- the request remains pending for the next low phase
REQ-030 A rise during DMA_ACK still completes the ack pulse on that cycle; the FSM enters CPU on the next edge.
REQ-031 dma_req falling before ack is ignored until the FSM next leaves IDLE/CPU.

Reset
REQ-032 While rst = 0:
- the FSM is in IDLE
- phi_q = 0
- all strobes and dma_ack = 0
- mem_addr = 0, mem_wdata = 0, dma_rdata = 0
REQ-033 Reset deassertion mid-transfer restarts cleanly: no ack and no write strobe occur for a transfer cut by reset.

Structure
REQ-034 A shared package holds:
- the state encoding
- the address-map constants SRAM_BASE = $0000, SRAM_TOP = $1FFF, IO_TOP = $7FFF, ROM_BASE = $8000
REQ-035 Address decode is a combinational sub-module, addr_decode, reusable by board-level logic.

Verification
REQ-036 After reset, phi_0 toggles, CPU reads $8000 with cpu_rw = 1 -> rom_oe = 1 during phi_0 high only; sram_en = 0.
REQ-037 CPU writes $AA to $0000 -> sram_en = sram_we = 1 and mem_wdata = $AA in the CPU phase; a later CPU read of $0000 returns $AA.
REQ-038 dma_req with dma_rw = 0, dma_addr = $1FFF, dma_wdata = $55 -> write occurs in the next phi_0-low phase, dma_ack pulses exactly once 3 clk after fall, and a CPU read of $1FFF returns $55.
REQ-039 DMA read of $0000 after REQ-037 -> dma_rdata = $AA with dma_ack.
REQ-040 phi_0 low phase of 2 clk (LOW_MIN violated) -> transfer aborted, no ack; with the low phase restored to 4 clk, the ack follows in the next low phase.
REQ-041 rst asserted in DMA_DATA -> outputs reach reset values immediately; no ack occurs.
